key_conditioner: RTL and testbench

Front-end input stage between the raw board push-buttons (`KEY`, active-low) and the core logic of the `Final_3002` top level. It synchronizes each key into the `CLOCK_50` domain and debounces it with a per-key counter. It emits clean, single-cycle press, release and auto-repeat strobes, plus a debounced active-high level. The downstream display and counter logic consumes only these strobes and never samples `KEY` directly.

---
 rtl/key_cond_pkg.sv | 25 ++
 rtl/key_channel.sv | 131 +++++++++++++
 rtl/key_conditioner.sv | 35 +++
 tb/tb_key_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and timing constants for the push-button conditioner.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Board timing at 50 MHz: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat rate.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    // Shortened timing so simulation reaches every state in a few dozen cycles.
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_REPEAT_DELAY    = 10;
    localparam int SIM_REPEAT_PERIOD   = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce FSM and auto-repeat timer.
//
//   state        | meaning
//   -------------+-------------------------------------------------
//   IDLE         | debounced released, waiting for a pressed sample
//   PRESS_WAIT   | counting consecutive pressed samples
//   HELD         | debounced pressed, repeat timer running
//   RELEASE_WAIT | counting consecutive released samples, timer frozen
module key_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

    logic [1:0]       sync_q;
    logic             s;
    key_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RPT_W-1:0] rpt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;

    // Bring the raw key into the clock domain; resets to "released".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_raw_i};
        end
    end

    assign s = ~sync_q[1];

    // Debounce FSM with registered strobes. The repeat timer counts down to
    // one; it is loaded with the full delay on a new press and left untouched
    // while a release is being qualified, so a bounce resumes where it was.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rpt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_TC) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        level_q <= 1'b1;
                        rpt_q   <= RPT_FIRST;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_ONE;
                    end else if ((REPEAT_DELAY != 0) && (rpt_q != '0)) begin
                        if (rpt_q == RPT_ONE) begin
                            repeat_q <= 1'b1;
                            rpt_q    <= RPT_NEXT;
                        end else begin
                            rpt_q <= rpt_q - 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_TC) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button front end: one independent debounce channel per key.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk_i    (CLOCK_50),
            .rst_ni   (RESET_N),
            .key_raw_i(KEY[i]),
            .level_o  (key_level[i]),
            .press_o  (key_press[i]),
            .release_o(key_release[i]),
            .repeat_o (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with a cycle-level behavioural model.
module tb_key_conditioner;
    import key_cond_pkg::*;

    localparam int NK  = 2;
    localparam int DEB = SIM_DEBOUNCE_CYCLES;
    localparam int RD  = SIM_REPEAT_DELAY;
    localparam int RP  = SIM_REPEAT_PERIOD;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [NK-1:0] key   = '1;
    logic [NK-1:0] key_level, key_press, key_release, key_repeat;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .KEY        (key),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_repeat (key_repeat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [NK-1:0] lvl;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
        logic [NK-1:0] rpt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    // Reference model: the core sees KEY two edges late; a level change is
    // accepted once the seen value has differed from the debounced level for
    // DEB+1 consecutive edges. Repeats come from the number of pressed edges
    // spent settled in the held state since the last press.
    bit m_d1[NK], m_d2[NK], m_lvl[NK];
    int m_run[NK], m_tick[NK];

    // Recorded strobe times for the directed latency checks.
    int press_at[NK], rel_at[NK], rep_first[NK], rep_n[NK];

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_d1[i] = 1'b1; m_d2[i] = 1'b1; m_lvl[i] = 1'b0;
            m_run[i] = 0;   m_tick[i] = 0;
        end
    endtask

    task automatic clr_rec();
        for (int i = 0; i < NK; i++) begin
            press_at[i] = -1; rel_at[i] = -1; rep_first[i] = -1; rep_n[i] = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({key_level, key_press, key_release, key_repeat} != '0) begin
            errors++;
            $display("FAIL %s@%0d: got lvl=%b prs=%b rel=%b rpt=%b expected all zero",
                     name, cyc, key_level, key_press, key_release, key_repeat);
        end
    endtask

    // Apply one cycle of stimulus and queue the expected outputs for that edge.
    task automatic step(input logic [NK-1:0] k);
        exp_t e;
        e.cyc = cyc + 1;
        e.prs = '0; e.rel = '0; e.rpt = '0; e.lvl = '0;
        key = k;
        for (int i = 0; i < NK; i++) begin
            bit s, settled;
            s       = ~m_d2[i];
            m_d2[i] = m_d1[i];
            m_d1[i] = k[i];
            settled = m_lvl[i] && (m_run[i] == 0);
            if (s != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB + 1) begin
                    m_lvl[i] = s;
                    m_run[i] = 0;
                    if (s) begin
                        e.prs[i]  = 1'b1;
                        m_tick[i] = 0;
                    end else begin
                        e.rel[i] = 1'b1;
                    end
                end
            end else begin
                m_run[i] = 0;
                if (settled && s && RD != 0) begin
                    m_tick[i]++;
                    if (m_tick[i] == RD || (m_tick[i] > RD && (m_tick[i] - RD) % RP == 0))
                        e.rpt[i] = 1'b1;
                end
            end
            e.lvl[i] = m_lvl[i];
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n, input logic [NK-1:0] k);
        rst_n  = 1'b0;
        key    = k;
        mon_en = 1'b0;
        q.delete();
        model_reset();
        #1;
        check_zero("reset_async");
        repeat (n) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    exp_t me;
    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL stale_expectation: got cycle %0d expected entry for cycle %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                me = q.pop_front();
                checks++;
                if ({key_level, key_press, key_release, key_repeat} != {me.lvl, me.prs, me.rel, me.rpt}) begin
                    errors++;
                    $display("FAIL outputs@%0d: got lvl=%b prs=%b rel=%b rpt=%b expected lvl=%b prs=%b rel=%b rpt=%b",
                             cyc, key_level, key_press, key_release, key_repeat,
                             me.lvl, me.prs, me.rel, me.rpt);
                end
            end else if ({key_level, key_press, key_release, key_repeat} != '0) begin
                checks++; errors++;
                $display("FAIL unexpected_output@%0d: got lvl=%b prs=%b rel=%b rpt=%b expected all zero",
                         cyc, key_level, key_press, key_release, key_repeat);
            end
            for (int i = 0; i < NK; i++) begin
                if (key_press[i])   press_at[i] = cyc;
                if (key_release[i]) rel_at[i]   = cyc;
                if (key_repeat[i]) begin
                    if (rep_n[i] == 0) rep_first[i] = cyc;
                    rep_n[i]++;
                end
            end
        end
    end

    initial begin
        int t0, tr;
        int rem[NK];
        logic [NK-1:0] kv;

        model_reset();
        clr_rec();
        @(negedge clk);

        // Reset, then idle with both keys released.
        do_reset(3, 2'b11);
        repeat (20) step(2'b11);

        // KEY[0] pressed and held, then released.
        clr_rec();
        t0 = cyc + 1;
        repeat (44) step(2'b10);
        tr = cyc + 1;
        repeat (12) step(2'b11);
        chk("press_latency", press_at[0] - t0, DEB + 2);
        chk("first_repeat", rep_first[0] - press_at[0], RD);
        chk("repeat_count", rep_n[0], 6);
        chk("release_latency", rel_at[0] - tr, DEB + 2);
        chk("ch1_no_press", press_at[1], -1);

        // KEY[1] bouncing shorter than the debounce window.
        clr_rec();
        for (int r = 0; r < 5; r++) begin
            repeat (3) step(2'b01);
            repeat (3) step(2'b11);
        end
        repeat (8) step(2'b11);
        chk("bounce_no_press", press_at[1], -1);
        chk("bounce_no_release", rel_at[1], -1);

        // Both keys pressed together, released separately.
        clr_rec();
        t0 = cyc + 1;
        repeat (10) step(2'b00);
        repeat (10) step(2'b01);
        repeat (12) step(2'b11);
        chk("dual_press_same_cycle", press_at[1] - press_at[0], 0);
        chk("dual_press_latency", press_at[0] - t0, DEB + 2);
        chk("dual_release_gap", rel_at[1] - rel_at[0], 10);

        // Reset while KEY[0] is held; key still down after reset.
        repeat (12) step(2'b10);
        do_reset(3, 2'b10);
        clr_rec();
        t0 = cyc + 1;
        repeat (10) step(2'b10);
        chk("post_reset_press", press_at[0] - t0, DEB + 2);
        chk("post_reset_no_release", rel_at[0], -1);
        repeat (12) step(2'b11);

        // Random key activity with runs of varying length.
        for (int i = 0; i < NK; i++) rem[i] = 0;
        kv = 2'b11;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (rem[i] == 0) begin
                    kv[i]  = 1'($urandom_range(0, 1));
                    rem[i] = $urandom_range(1, 12);
                end
                rem[i]--;
            end
            step(kv);
        end
        repeat (12) step(2'b11);

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
